// File: rtl/i2s_frame_sched_if.sv
`timescale 1ns/1ps
// DSP-engine handshake and frame-stable settings shared between the frame
// scheduler (master) and the chorus/effect DSP engine (slave).
interface i2s_frame_sched_if;
    logic       dsp_ready_i;
    logic       dsp_done_i;
    logic       dsp_start_o;
    logic       dsp_chan_o;
    logic [3:0] freq_setting_o;
    logic [3:0] scale_factor_o;

    modport master (
        input  dsp_ready_i,
        input  dsp_done_i,
        output dsp_start_o,
        output dsp_chan_o,
        output freq_setting_o,
        output scale_factor_o
    );

    modport slave (
        output dsp_ready_i,
        output dsp_done_i,
        input  dsp_start_o,
        input  dsp_chan_o,
        input  freq_setting_o,
        input  scale_factor_o
    );
endinterface

// File: rtl/i2s_frame_sched.sv
`timescale 1ns/1ps
// Frame-level sequencer: tracks WS, issues one DSP job per completed channel
// word, latches settings at frame starts, sequences I2S reset, flags faults.
module i2s_frame_sched #(
    parameter int DATA_W         = 16,
    parameter int STARTUP_FRAMES = 4
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       ws_i,
    input  logic [3:0] freq_setting_i,
    input  logic [3:0] scale_factor_i,
    output logic       rst_i2s_n_o,
    output logic       err_o,
    i2s_frame_sched_if.master dsp
);
    localparam int               CNT_W      = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_DONE   = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(DATA_W + 1);
    localparam logic [7:0]       LAST_FRAME = 8'(STARTUP_FRAMES - 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_SYNC,
        ST_IDLE,
        ST_PEND,
        ST_START,
        ST_BUSY
    } state_t;

    state_t           state_reg;
    logic             ws_q_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [7:0]       frame_cnt_reg;
    logic             cur_chan_reg;

    logic ws_edge;
    logic ws_fall;
    logic word_done;
    logic short_word;
    logic in_frame;
    logic take_word;
    logic latch_settings;

    assign ws_edge    = (ws_i != ws_q_reg);
    assign ws_fall    = ws_edge & ~ws_i;
    assign word_done  = (cnt_reg == CNT_DONE);
    assign short_word = (cnt_reg < CNT_DONE);
    assign in_frame   = (state_reg != ST_INIT) && (state_reg != ST_SYNC);

    // A word completing in the same cycle the running job finishes is
    // handled exactly as if the engine had already been idle.
    assign take_word = word_done &&
                       ((state_reg == ST_IDLE) ||
                        ((state_reg == ST_BUSY) && dsp.dsp_done_i));

    assign latch_settings = ws_fall &&
                            ((state_reg == ST_SYNC) || (state_reg == ST_IDLE) ||
                             (state_reg == ST_BUSY) || (state_reg == ST_PEND));

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state_reg          <= ST_INIT;
            ws_q_reg           <= 1'b0;
            cnt_reg            <= '0;
            frame_cnt_reg      <= '0;
            cur_chan_reg       <= 1'b0;
            rst_i2s_n_o        <= 1'b0;
            err_o              <= 1'b0;
            dsp.dsp_start_o    <= 1'b0;
            dsp.dsp_chan_o     <= 1'b0;
            dsp.freq_setting_o <= '0;
            dsp.scale_factor_o <= '0;
        end else begin
            ws_q_reg        <= ws_i;
            dsp.dsp_start_o <= 1'b0;

            if (ws_edge) begin
                cnt_reg <= '0;
            end else if (cnt_reg != CNT_SAT) begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            if (latch_settings) begin
                dsp.freq_setting_o <= freq_setting_i;
                dsp.scale_factor_o <= scale_factor_i;
            end

            // Short half-frame: drop any pending word and resynchronise; a
            // job already running on the engine finishes without tracking.
            if (in_frame && ws_edge && short_word) begin
                err_o     <= 1'b1;
                state_reg <= ST_SYNC;
            end else if (take_word) begin
                cur_chan_reg <= ws_q_reg;
                if (dsp.dsp_ready_i) begin
                    dsp.dsp_start_o <= 1'b1;
                    dsp.dsp_chan_o  <= ws_q_reg;
                    state_reg       <= ST_START;
                end else begin
                    state_reg <= ST_PEND;
                end
            end else begin
                case (state_reg)
                    ST_INIT: begin
                        if (ws_fall) begin
                            frame_cnt_reg <= frame_cnt_reg + 8'd1;
                            if (frame_cnt_reg == LAST_FRAME) begin
                                state_reg   <= ST_SYNC;
                                rst_i2s_n_o <= 1'b1;
                            end
                        end
                    end
                    ST_SYNC: begin
                        if (ws_fall) begin
                            cur_chan_reg <= 1'b0;
                            state_reg    <= ST_IDLE;
                        end
                    end
                    ST_PEND: begin
                        if (word_done) begin
                            err_o <= 1'b1;
                        end
                        if (dsp.dsp_ready_i) begin
                            dsp.dsp_start_o <= 1'b1;
                            dsp.dsp_chan_o  <= cur_chan_reg;
                            state_reg       <= ST_START;
                        end
                    end
                    ST_START: begin
                        state_reg <= ST_BUSY;
                    end
                    ST_BUSY: begin
                        if (dsp.dsp_done_i) begin
                            state_reg <= ST_IDLE;
                        end else if (word_done) begin
                            err_o <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule
